// File: rtl/rewind_replay_if.sv
// Dcache array update port used by the rewind replay engine.
// The engine drives the write request (master); the dcache array grants and acks it (slave).
interface rewind_replay_if;
    logic        cache_req;
    logic [31:0] cache_addr;
    logic [31:0] cache_wdata;
    logic [3:0]  cache_be;
    logic [2:0]  cache_op;
    logic        cache_gnt;
    logic        cache_ack;

    modport master (
        output cache_req,
        output cache_addr,
        output cache_wdata,
        output cache_be,
        output cache_op,
        input  cache_gnt,
        input  cache_ack
    );

    modport slave (
        input  cache_req,
        input  cache_addr,
        input  cache_wdata,
        input  cache_be,
        input  cache_op,
        output cache_gnt,
        output cache_ack
    );
endinterface

// File: rtl/rewind_replay.sv
// Rewind replay engine: after an ROB resteer, drains the dcache rewind buffer one entry at a
// time, writes each saved pre-store word back into the dcache array via the UPD port, pops the
// entry, and holds the front-end until the buffer has been idle for DRAIN_IDLE cycles.
module rewind_replay #(
    parameter int OOO_TAG_SIZE = 10,
    parameter int ACK_TIMEOUT  = 16,
    parameter int DRAIN_IDLE   = 2,
    parameter int CNT_W        = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    rob_resteer,
    input  logic                    valid_rewind,
    input  logic [31:0]             addr_in,
    input  logic [31:0]             data_in,
    input  logic [2:0]              operation_in,
    input  logic [1:0]              size_in,
    input  logic [OOO_TAG_SIZE-1:0] ooo_tag_in,
    output logic                    dealloc,
    rewind_replay_if.master         cache,
    output logic                    pipe_hold,
    output logic                    rewind_done,
    output logic [CNT_W-1:0]        rewind_count,
    output logic [OOO_TAG_SIZE-1:0] last_tag,
    output logic                    err_misalign,
    output logic                    err_timeout
);

    localparam logic [2:0] OP_ST  = 3'd2;
    localparam logic [2:0] OP_UPD = 3'd6;

    localparam int IDLE_W = (DRAIN_IDLE < 2) ? 1 : $clog2(DRAIN_IDLE + 1);
    localparam int TMR_W  = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DRAIN_IDLE - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(DRAIN_IDLE);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_ISSUE,
        S_WAIT,
        S_POP,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [IDLE_W-1:0] idle_cnt;
    logic [TMR_W-1:0]  timer;

    // Entry latched at issue decision; the array sees a stable request until it is granted
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_be;
    logic        cur_write;

    // Combinational control
    logic       req;
    logic       pop;
    logic       take;
    logic       timeout;
    logic       done;
    logic       lane_legal;
    logic [3:0] lane_be;
    logic       is_st;
    logic       do_write;

    // Byte-enable decode for the head entry; bit 4 flags a legal size/alignment combination
    function automatic logic [4:0] lane_decode(input logic [1:0] size, input logic [1:0] a);
        logic [4:0] r;
        r = 5'b0;
        case (size)
            2'd0:    r = {1'b1, 4'b0001 << a};
            2'd1:    r = {~a[0], (a[1] ? 4'b1100 : 4'b0011)};
            2'd2:    r = {(a == 2'b00), 4'hF};
            default: r = 5'b0;
        endcase
        return r;
    endfunction

    // Restored-entry counter sticks at all ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Classify the current head entry: only legal stores are written back
    always_comb begin
        {lane_legal, lane_be} = lane_decode(size_in, addr_in[1:0]);
        is_st                 = (operation_in == OP_ST);
        do_write              = is_st && lane_legal;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state strobes
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        pop       = 1'b0;
        take      = 1'b0;
        timeout   = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (rob_resteer || valid_rewind) begin
                    state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                if (valid_rewind && !stall) begin
                    take      = 1'b1;
                    state_nxt = do_write ? S_ISSUE : S_POP;
                end else if (!valid_rewind && !rob_resteer && (idle_cnt == IDLE_LAST)) begin
                    // This cycle is the last of DRAIN_IDLE consecutive idle cycles
                    state_nxt = S_DONE;
                end
            end
            S_ISSUE: begin
                req = !stall;
                if (req && cache.cache_gnt) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // Stall is deliberately ignored here so an ack is never dropped
                if (cache.cache_ack) begin
                    state_nxt = S_POP;
                end else if (timer == TMR_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_POP: begin
                if (!stall) begin
                    pop       = 1'b1;
                    state_nxt = S_ARM;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Idle counter: measures consecutive empty-buffer cycles while armed; any resteer restarts it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
        end else if (state == S_IDLE) begin
            idle_cnt <= '0;
        end else if (rob_resteer) begin
            idle_cnt <= '0;
        end else if (state == S_ARM) begin
            if (valid_rewind) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    // Ack timer: restarts on every (re)issue, counts WAIT cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if (state == S_ISSUE) begin
            timer <= '0;
        end else if (state == S_WAIT && timer != TMR_LAST) begin
            timer <= timer + 1'b1;
        end
    end

    // Capture the write image of the head entry when it is taken from ARM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_addr  <= '0;
            cur_wdata <= '0;
            cur_be    <= '0;
            cur_write <= 1'b0;
        end else if (take) begin
            cur_addr  <= {addr_in[31:2], 2'b00};
            cur_wdata <= data_in;
            cur_be    <= do_write ? lane_be : 4'h0;
            cur_write <= do_write;
        end
    end

    // Drain bookkeeping: restored count, last popped tag, sticky error flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rewind_count <= '0;
            last_tag     <= '0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            if (state == S_IDLE && state_nxt == S_ARM) begin
                rewind_count <= '0;
            end else if (pop && cur_write) begin
                rewind_count <= sat_inc(rewind_count);
            end
            if (pop) begin
                last_tag <= ooo_tag_in;
            end
            if (take && is_st && !lane_legal) begin
                err_misalign <= 1'b1;
            end
            if (timeout) begin
                err_timeout <= 1'b1;
            end
        end
    end

    assign dealloc           = pop;
    assign rewind_done       = done;
    assign pipe_hold         = (state != S_IDLE);
    assign cache.cache_req   = req;
    assign cache.cache_op    = req ? OP_UPD : 3'd0;
    assign cache.cache_addr  = cur_addr;
    assign cache.cache_wdata = cur_wdata;
    assign cache.cache_be    = cur_be;

endmodule
